// File: rtl/psr_pkg.sv
// Shared definitions for the parametrised shift register: operation codes,
// burst controller states and a small mode classification helper.
package psr_pkg;

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_SHL  = 3'b001;
  localparam logic [2:0] MODE_SHR  = 3'b010;
  localparam logic [2:0] MODE_LOAD = 3'b011;
  localparam logic [2:0] MODE_ROL  = 3'b100;
  localparam logic [2:0] MODE_ROR  = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } psr_state_t;

  // True for the operations a burst is allowed to repeat (shifts and rotates).
  function automatic logic is_shift_op(input logic [2:0] m);
    logic r;
    case (m)
      MODE_SHL, MODE_SHR, MODE_ROL, MODE_ROR: r = 1'b1;
      default:                                r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/psr_burst_ctrl.sv
// Burst sequencer: IDLE/RUN/DONE FSM, burst length counter and the latched
// burst operation. Produces the operation select applied to the data register.
import psr_pkg::*;

module psr_burst_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [CNT_W-1:0] burst_len,
  output logic             busy,
  output logic             done,
  output logic [2:0]       op_sel
);

  psr_state_t       state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [CNT_W-1:0] len_s;
  logic [2:0]       burst_mode_r, burst_mode_s;
  logic             busy_r, done_r;

  // Clamp requested burst length to the register width.
  always_comb begin
    len_s = burst_len;
    if (burst_len > CNT_W'(WIDTH)) begin
      len_s = CNT_W'(WIDTH);
    end else begin
      len_s = burst_len;
    end
  end

  // Next-state, counter, burst latch and effective operation select.
  always_comb begin
    state_s      = state_r;
    cnt_s        = cnt_r;
    burst_mode_s = burst_mode_r;
    op_sel       = MODE_HOLD;
    case (state_r)
      IDLE: begin
        if (start) begin
          // start beats en: the direct op is dropped this cycle
          burst_mode_s = mode;
          if (len_s == {CNT_W{1'b0}}) begin
            state_s = DONE;
            cnt_s   = {CNT_W{1'b0}};
          end else begin
            state_s = RUN;
            cnt_s   = len_s;
          end
        end else if (en) begin
          op_sel = mode;
        end else begin
          op_sel = MODE_HOLD;
        end
      end
      RUN: begin
        // non-shift burst modes (HOLD, LOAD, reserved) just run out the count
        if (is_shift_op(burst_mode_r)) begin
          op_sel = burst_mode_r;
        end else begin
          op_sel = MODE_HOLD;
        end
        if (cnt_r > CNT_W'(1)) begin
          cnt_s = cnt_r - CNT_W'(1);
        end else begin
          cnt_s   = {CNT_W{1'b0}};
          state_s = DONE;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
        cnt_s   = {CNT_W{1'b0}};
      end
    endcase
  end

  // State, counter, burst latch and registered busy/done flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= IDLE;
      cnt_r        <= {CNT_W{1'b0}};
      burst_mode_r <= MODE_HOLD;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      state_r      <= state_s;
      cnt_r        <= cnt_s;
      burst_mode_r <= burst_mode_s;
      busy_r       <= (state_s == RUN);
      done_r       <= (state_s == DONE);
    end
  end

  assign busy = busy_r;
  assign done = done_r;

endmodule

// File: rtl/param_shift_register.sv
// WIDTH-stage shift register with shift/rotate/load, parallel readout and a
// counted burst-shift engine. Serialiser/deserialiser between parallel datapaths
// and single-wire links.
import psr_pkg::*;

module param_shift_register #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic             sin,
  input  logic [WIDTH-1:0] pdata_in,
  input  logic             start,
  input  logic [CNT_W-1:0] burst_len,
  output logic [WIDTH-1:0] q_par,
  output logic             sout_msb,
  output logic             sout_lsb,
  output logic             busy,
  output logic             done
);

  logic [2:0]       op_sel_s;
  logic [WIDTH-1:0] q_r, q_s;

  psr_burst_ctrl #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) u_ctrl (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .start    (start),
    .mode     (mode),
    .burst_len(burst_len),
    .busy     (busy),
    .done     (done),
    .op_sel   (op_sel_s)
  );

  // Operation mux selecting the next register contents.
  always_comb begin
    q_s = q_r;
    case (op_sel_s)
      MODE_SHL:  q_s = {q_r[WIDTH-2:0], sin};
      MODE_SHR:  q_s = {sin, q_r[WIDTH-1:1]};
      MODE_LOAD: q_s = pdata_in;
      MODE_ROL:  q_s = {q_r[WIDTH-2:0], q_r[WIDTH-1]};
      MODE_ROR:  q_s = {q_r[0], q_r[WIDTH-1:1]};
      default:   q_s = q_r;
    endcase
  end

  // Data register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_r <= {WIDTH{1'b0}};
    end else begin
      q_r <= q_s;
    end
  end

  assign q_par    = q_r;
  assign sout_msb = q_r[WIDTH-1];
  assign sout_lsb = q_r[0];

endmodule

// File: tb/tb_param_shift_register.sv
// Directed, scoreboard-based bench for param_shift_register (WIDTH=8).
module tb_param_shift_register;
  import psr_pkg::*;

  localparam int WIDTH = 8;
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic             clk, rst, en, sin, start;
  logic [2:0]       mode;
  logic [WIDTH-1:0] pdata_in, q_par;
  logic [CNT_W-1:0] burst_len;
  logic             sout_msb, sout_lsb, busy, done;

  int errors = 0;
  int checks = 0;

  string      tag_q[$];
  logic [9:0] exp_q[$];   // {q, busy, done}

  param_shift_register #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sin(sin),
    .pdata_in(pdata_in), .start(start), .burst_len(burst_len),
    .q_par(q_par), .sout_msb(sout_msb), .sout_lsb(sout_lsb),
    .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish, expected finish before 100us");
    $fatal(1, "watchdog");
  end

  task automatic check_now(input string tag, input logic [7:0] eq,
                           input logic eb, input logic ed);
    logic [11:0] obs, expv;
    obs  = {q_par, sout_msb, sout_lsb, busy, done};
    expv = {eq, eq[7], eq[0], eb, ed};
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed q=%h msb=%b lsb=%b busy=%b done=%b expected q=%h msb=%b lsb=%b busy=%b done=%b",
             tag, q_par, sout_msb, sout_lsb, busy, done, eq, eq[7], eq[0], eb, ed);
    end
  endtask

  // push the expectation for the coming edge, clock, then drain the scoreboard
  task automatic cycle(input string tag, input logic [7:0] eq,
                       input logic eb, input logic ed);
    logic [9:0] e;
    string      t;
    tag_q.push_back(tag);
    exp_q.push_back({eq, eb, ed});
    @(posedge clk);
    #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check_now(t, e[9:2], e[1], e[0]);
    end
  endtask

  task automatic do_load(input logic [7:0] v);
    en = 1'b1; mode = MODE_LOAD; pdata_in = v;
    cycle("load", v, 1'b0, 1'b0);
    en = 1'b0; mode = MODE_HOLD; pdata_in = 8'h00;
  endtask

  initial begin
    logic [7:0] m;
    logic [7:0] pat;

    rst = 1'b0; en = 1'b0; sin = 1'b0; start = 1'b0;
    mode = MODE_HOLD; pdata_in = 8'h00; burst_len = 4'd0;
    #2;
    check_now("reset_initial", 8'h00, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;

    // asynchronous reset from a non-zero state
    do_load(8'hA5);
    rst = 1'b0;
    #1;
    check_now("async_reset", 8'h00, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check_now("reset_held", 8'h00, 1'b0, 1'b0);
    rst = 1'b1;

    // direct shifts, reserved mode, en low
    do_load(8'h81);
    en = 1'b1; mode = MODE_SHL; sin = 1'b0;
    cycle("direct_shl", 8'h02, 1'b0, 1'b0);
    mode = MODE_SHR; sin = 1'b1;
    cycle("direct_shr", 8'h81, 1'b0, 1'b0);
    mode = 3'b110;
    cycle("reserved_hold", 8'h81, 1'b0, 1'b0);
    en = 1'b0; mode = MODE_SHL;
    cycle("en_low_hold", 8'h81, 1'b0, 1'b0);
    mode = MODE_HOLD; sin = 1'b0;

    // burst ROL of 3
    do_load(8'h01);
    start = 1'b1; mode = MODE_ROL; burst_len = 4'd3;
    cycle("rol_start", 8'h01, 1'b1, 1'b0);
    start = 1'b0; mode = MODE_HOLD;
    cycle("rol_1", 8'h02, 1'b1, 1'b0);
    cycle("rol_2", 8'h04, 1'b1, 1'b0);
    cycle("rol_done", 8'h08, 1'b0, 1'b1);
    cycle("rol_idle", 8'h08, 1'b0, 1'b0);

    // serial-in burst of 8, with start/LOAD noise during RUN
    do_load(8'h00);
    pat = 8'b1011_0010;
    start = 1'b1; mode = MODE_SHL; burst_len = 4'd8;
    cycle("siso_start", 8'h00, 1'b1, 1'b0);
    start = 1'b0;
    m = 8'h00;
    for (int k = 0; k < 8; k++) begin
      sin = pat[7-k];
      if (k >= 1 && k <= 4) begin
        start = 1'b1; en = 1'b1; mode = MODE_LOAD; pdata_in = 8'hFF;
      end else begin
        start = 1'b0; en = 1'b0; mode = MODE_HOLD; pdata_in = 8'h00;
      end
      m = {m[6:0], sin};
      cycle("siso_step", m, (k < 7), (k == 7));
    end
    start = 1'b0; en = 1'b0; mode = MODE_HOLD; sin = 1'b0;
    cycle("siso_idle", 8'hB2, 1'b0, 1'b0);

    // zero-length burst
    start = 1'b1; mode = MODE_SHL; sin = 1'b1; burst_len = 4'd0;
    cycle("len0_done", 8'hB2, 1'b0, 1'b1);
    start = 1'b0; mode = MODE_HOLD; sin = 1'b0;
    cycle("len0_idle", 8'hB2, 1'b0, 1'b0);

    // over-long burst clamps to 8 rotates
    do_load(8'h01);
    start = 1'b1; mode = MODE_ROL; burst_len = 4'd15;
    cycle("len15_start", 8'h01, 1'b1, 1'b0);
    start = 1'b0; mode = MODE_HOLD;
    m = 8'h01;
    for (int k = 0; k < 8; k++) begin
      m = {m[6:0], m[7]};
      cycle("len15_step", m, (k < 7), (k == 7));
    end
    cycle("len15_idle", 8'h01, 1'b0, 1'b0);

    // start and LOAD together: burst wins, LOAD burst holds q
    start = 1'b1; en = 1'b1; mode = MODE_LOAD; pdata_in = 8'hFF; burst_len = 4'd2;
    cycle("start_over_load", 8'h01, 1'b1, 1'b0);
    start = 1'b0; en = 1'b0; mode = MODE_HOLD; pdata_in = 8'h00;
    cycle("load_burst_hold", 8'h01, 1'b1, 1'b0);
    cycle("load_burst_done", 8'h01, 1'b0, 1'b1);
    cycle("load_burst_idle", 8'h01, 1'b0, 1'b0);

    // reset in the middle of a burst
    start = 1'b1; mode = MODE_ROR; burst_len = 4'd5;
    cycle("ror_start", 8'h01, 1'b1, 1'b0);
    start = 1'b0; mode = MODE_HOLD;
    cycle("ror_1", 8'h80, 1'b1, 1'b0);
    #1;
    rst = 1'b0;
    #1;
    check_now("rst_in_run", 8'h00, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check_now("rst_in_run_held", 8'h00, 1'b0, 1'b0);
    rst = 1'b1;
    cycle("post_rst_idle", 8'h00, 1'b0, 1'b0);
    cycle("post_rst_no_done", 8'h00, 1'b0, 1'b0);
    do_load(8'h3C);
    en = 1'b1; mode = MODE_ROR;
    cycle("post_rst_ror", 8'h1E, 1'b0, 1'b0);
    en = 1'b0; mode = MODE_HOLD;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/param_shift_register.md
Name: param_shift_register

Overview:
Parametrised successor to the team's fixed 4-stage serial-in/serial-out shift register.
- Generalised to WIDTH stages.
- Adds bidirectional shift, rotate, parallel load/readout and a counted burst-shift engine with busy/done handshake.
- Used as the serialiser/deserialiser stage between parallel datapaths and single-wire links.

Parameters:
- WIDTH, 8, number of register stages (legal range ≥2).
- CNT_W, $clog2(WIDTH+1), width of the burst length field (derived; not overridden by users).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset; asynchronous, active-low; asserts immediately, releases synchronously to clk.
- en  input  1  direct-operation enable; ignored while busy.
- mode  input  3  operation select (see Behaviour).
- sin  input  1  serial data in.
- pdata_in  input  WIDTH  parallel load data.
- start  input  1  burst request; sampled only in IDLE.
- burst_len  input  CNT_W  number of burst shift cycles.
- q_par  output  WIDTH  register contents (registered).
- sout_msb  output  1  equals q_par[WIDTH-1].
- sout_lsb  output  1  equals q_par[0].
- busy  output  1  high while a burst is running.
- done  output  1  one-cycle pulse at burst completion.

Behaviour:
- Reset (rst=0): q_par=0, busy=0, done=0, FSM=IDLE, counter=0; sout_msb/sout_lsb therefore 0. Reset mid-burst aborts the burst with no done pulse.
- All state updates on rising clk; q_par changes the cycle after the controlling inputs are sampled (latency 1).
- Mode encoding:
  - 000 HOLD.
  - 001 SHL: q <= {q[W-2:0], sin}.
  - 010 SHR: q <= {sin, q[W-1:1]}.
  - 011 LOAD: q <= pdata_in.
  - 100 ROL: q <= {q[W-2:0], q[W-1]}.
  - 101 ROR: q <= {q[0], q[W-1:1]}.
  - 110/111: reserved, behave as HOLD.
- Direct operation: in IDLE with en=1 and start=0, apply mode once per cycle. en=0 means hold.
- FSM states: IDLE, RUN, DONE.
- IDLE -> RUN on start=1:
  - Latch mode into burst_mode and load counter with min(burst_len, WIDTH).
  - start has priority over en in the same cycle; the direct op is not applied.
- Burst mode validity:
  - If the latched burst_mode is not a shift/rotate (i.e. HOLD, LOAD or reserved), the burst still runs for its count but q holds.
  - LOAD is never repeated.
- RUN: each cycle apply burst_mode (sin sampled every cycle) and decrement counter. When counter reaches 1, apply the last op and go to DONE.
- burst_len=0: IDLE -> DONE directly, with no shift.
- DONE: done=1 for exactly one cycle, then IDLE. busy=0 in DONE, so a new start is accepted in the cycle after DONE.
- busy=1 exactly in RUN; an N-cycle burst gives busy high for N cycles.
- While busy: start, en, mode and pdata_in are ignored.
- burst_len values above WIDTH are clamped to WIDTH.
- No arithmetic on data; the only arithmetic is the CNT_W-bit counter decrement, which never underflows.

Decomposition:
- Package psr_pkg holds:
  - Mode constants MODE_HOLD..MODE_ROR (3-bit).
  - FSM state typedef {IDLE, RUN, DONE}.
- One sub-module, psr_burst_ctrl, holds the FSM, counter and burst_mode latch. It outputs busy, done and the effective op select.
- The top level holds the WIDTH-bit register and the op mux.

Test Plan:
- Reset: assert rst=0 mid-operation with q_par=8'hA5 -> q_par=8'h00, busy=0, done=0 immediately, without waiting for a clk edge.
- Direct SHL then SHR (WIDTH=8):
  - Start from LOAD of 8'h81.
  - SHL with sin=0 -> 8'h02.
  - SHR with sin=1 -> 8'h81.
- Burst ROL: q=8'h01, start with mode=100 and burst_len=3 -> busy high for 3 cycles; q steps 02, 04, 08; done pulses once; then IDLE.
- Burst SISO: q=0, burst SHL with burst_len=8 and sin pattern 1,0,1,1,0,0,1,0 -> q_par=8'hB2 and sout_msb=1 at done.
- Boundaries:
  - burst_len=0 -> done pulses the next cycle, busy never rises, q unchanged.
  - burst_len=15 -> clamped; exactly 8 shifts.
- Contention:
  - start and en (LOAD) in the same cycle -> burst wins, no load.
  - start/LOAD asserted during RUN -> ignored.
  - Reset during RUN -> no done pulse, IDLE after release.
